// File: rtl/vga_timing_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_timing_ctrl
// Description : VGA raster timing generator and output stage. Produces pixel
//               coordinates for a registered pattern generator, re-registers
//               the RGB it returns one clock later, blanks it outside the
//               active area and emits HS/VS/BLANK_N aligned to those pixels.
//               Counter position to pins is a fixed 2-clock latency.
//               Optional macro VGA_FRAME_CNT_EN adds an 8-bit frame counter
//               output (oFrame_Cnt) in the counter domain.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl #(
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic [7:0] iRed,
    input  logic [7:0] iGreen,
    input  logic [7:0] iBlue,
    output logic [9:0] oVGA_X,
    output logic [9:0] oVGA_Y,
    output logic [7:0] oVGA_R,
    output logic [7:0] oVGA_G,
    output logic [7:0] oVGA_B,
    output logic       oVGA_HS,
    output logic       oVGA_VS,
    output logic       oVGA_BLANK_N,
    output logic       oFrame_Start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] oFrame_Cnt
`endif
);

    // Raster geometry; order within a line/frame is active, FP, sync, BP
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOT - 1);
    localparam logic [10:0] H_ACT_END  = 11'(H_ACT);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACT);
    localparam logic [10:0] HS_START   = 11'(H_ACT + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACT + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACT + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACT + V_FP + V_SYNC);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_wrap;
    logic        v_wrap;

    // Stage 0 decode (straight from the counter registers)
    logic h_act;
    logic v_act;
    logic act;
    logic hs_a;
    logic vs_a;

    // Stage 1 of the control delay line
    logic act_d1;
    logic hs_d1;
    logic vs_d1;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Raster counters: h every clock, v on h wrap; both wrap together at frame end
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            if (v_wrap) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 11'd1;
            end
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    // Stage 0 decode of active area, sync windows, coordinates and frame start
    always_comb begin
        h_act        = (h_cnt < H_ACT_END);
        v_act        = (v_cnt < V_ACT_END);
        act          = h_act && v_act;
        hs_a         = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_a         = (v_cnt >= VS_START) && (v_cnt < VS_END);
        oVGA_X       = h_act ? h_cnt[9:0] : 10'd0;
        oVGA_Y       = v_act ? v_cnt[9:0] : 10'd0;
        oFrame_Start = (h_cnt == 11'd0) && (v_cnt == 11'd0);
    end

    // First control delay stage, matching the pattern generator's own register
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            act_d1 <= 1'b0;
            hs_d1  <= 1'b0;
            vs_d1  <= 1'b0;
        end else begin
            act_d1 <= act;
            hs_d1  <= hs_a;
            vs_d1  <= vs_a;
        end
    end

    // Output stage: capture returned RGB with blanking, and drive sync levels
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oVGA_R       <= 8'h00;
            oVGA_G       <= 8'h00;
            oVGA_B       <= 8'h00;
            oVGA_BLANK_N <= 1'b0;
            oVGA_HS      <= ~HS_POL;
            oVGA_VS      <= ~VS_POL;
        end else begin
            oVGA_R       <= act_d1 ? iRed   : 8'h00;
            oVGA_G       <= act_d1 ? iGreen : 8'h00;
            oVGA_B       <= act_d1 ? iBlue  : 8'h00;
            oVGA_BLANK_N <= act_d1;
            oVGA_HS      <= hs_d1 ? HS_POL : ~HS_POL;
            oVGA_VS      <= vs_d1 ? VS_POL : ~VS_POL;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter advances on the edge the raster wraps back to (0,0)
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oFrame_Cnt <= 8'h00;
        end else if (h_wrap && v_wrap) begin
            oFrame_Cnt <= oFrame_Cnt + 8'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_ctrl
// Description : Scoreboard bench for vga_timing_ctrl on a scaled-down raster
//               (21 clocks x 10 lines). A registered pattern generator model
//               feeds RGB back; expected pin values are queued when stimulus
//               is applied and popped by a monitor every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

    localparam int H_ACT  = 12;
    localparam int H_FP   = 3;
    localparam int H_SYNC = 4;
    localparam int H_BP   = 2;
    localparam int V_ACT  = 5;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 1;
    localparam int H_TOT  = 21;
    localparam int V_TOT  = 10;
    localparam int F_TOT  = H_TOT * V_TOT;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       blank_n;
        logic       hs;
        logic       vs;
    } pins_t;

    localparam pins_t IDLE = '{r: 8'h00, g: 8'h00, b: 8'h00, blank_n: 1'b0, hs: 1'b1, vs: 1'b1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] red = 8'h00;
    logic [7:0] green = 8'h00;
    logic [7:0] blue = 8'h00;
    logic [9:0] vga_x;
    logic [9:0] vga_y;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    pins_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    bit    running = 1'b0;
    bit    ff_mode = 1'b0;
    int    cyc = 0;

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .iVGA_CLK    (clk),
        .iRST_n      (rst_n),
        .iRed        (red),
        .iGreen      (green),
        .iBlue       (blue),
        .oVGA_X      (vga_x),
        .oVGA_Y      (vga_y),
        .oVGA_R      (vga_r),
        .oVGA_G      (vga_g),
        .oVGA_B      (vga_b),
        .oVGA_HS     (vga_hs),
        .oVGA_VS     (vga_vs),
        .oVGA_BLANK_N(vga_blank_n),
        .oFrame_Start(frame_start)
`ifdef VGA_FRAME_CNT_EN
        ,
        .oFrame_Cnt  (frame_cnt)
`endif
    );

    // Clocks elapsed since the last reset release (index of the current cycle)
    always @(posedge clk) begin
        if (!running) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, got, want, cyc, $time);
        end
    endtask

    function automatic pins_t pins_now();
        return '{r: vga_r, g: vga_g, b: vga_b, blank_n: vga_blank_n, hs: vga_hs, vs: vga_vs};
    endfunction

    // Expected pins for raster position p (p clocks after (0,0))
    function automatic pins_t exp_pins(input int p, input bit ff);
        int    h = p % H_TOT;
        int    v = (p / H_TOT) % V_TOT;
        bit    act = (h < H_ACT) && (v < V_ACT);
        logic [7:0] x8 = 8'(h);
        logic [7:0] y8 = 8'(v);
        pins_t e;
        e.blank_n = act;
        e.hs = !((h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYNC));
        e.vs = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYNC));
        if (!act) begin
            e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
        end else if (ff) begin
            e.r = 8'hFF; e.g = 8'hFF; e.b = 8'hFF;
        end else begin
            e.r = x8; e.g = y8; e.b = x8 + y8;
        end
        return e;
    endfunction

    // Expected {X, Y, frame_start} for the counter position of cycle c
    function automatic logic [20:0] exp_ctr(input int c);
        int h = c % H_TOT;
        int v = (c / H_TOT) % V_TOT;
        logic [9:0] x = (h < H_ACT) ? 10'(h) : 10'd0;
        logic [9:0] y = (v < V_ACT) ? 10'(v) : 10'd0;
        return {x, y, ((c % F_TOT) == 0)};
    endfunction

    // Pattern generator model: registers the requested coordinate's colour,
    // and the expected pin response for that coordinate is queued alongside
    initial begin : driver
        logic [9:0] xs;
        logic [9:0] ys;
        forever begin
            @(negedge clk);
            xs = vga_x;
            ys = vga_y;
            @(posedge clk);
            #1;
            if (running) begin
                if (ff_mode) begin
                    red = 8'hFF; green = 8'hFF; blue = 8'hFF;
                end else begin
                    red = xs[7:0]; green = ys[7:0]; blue = xs[7:0] + ys[7:0];
                end
                exp_q.push_back(exp_pins(cyc - 1, ff_mode));
            end
        end
    end

    // Monitor: every cycle, pop the queued pin expectation and check the
    // counter-domain outputs against the raster model
    initial begin : monitor
        pins_t want;
        forever begin
            @(negedge clk);
            if (running) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_underflow: got empty queue expected entry (cycle %0d)", cyc);
                end else begin
                    want = exp_q.pop_front();
                    check("pins", 64'(pins_now()), 64'(want));
                end
                check("xy_fs", 64'({vga_x, vga_y, frame_start}), 64'(exp_ctr(cyc)));
`ifdef VGA_FRAME_CNT_EN
                check("frame_cnt", 64'(frame_cnt), 64'((cyc / F_TOT) % 256));
`endif
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        exp_q.delete();
        exp_q.push_back(IDLE);
        rst_n   = 1'b1;
        running = 1'b1;
    endtask

    // First HS assertion must land H_ACT+H_FP+2 edges after release
    task automatic measure_hs_fall();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (vga_hs !== 1'b0 && n < 4 * H_TOT);
        check("hs_first_fall", 64'(n), 64'(H_ACT + H_FP + 2));
    endtask

    // Drop reset asynchronously at counter position (hpos, vpos)
    task automatic mid_reset(input int hpos, input int vpos);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((cyc % H_TOT) == hpos && ((cyc / H_TOT) % V_TOT) == vpos) && n < 2 * F_TOT);
        if (n >= 2 * F_TOT) begin
            total++;
            bad++;
            $display("FAIL mid_reset_wait: got timeout expected position %0d,%0d", hpos, vpos);
        end
        #2;
        running = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("async_rst_pins", 64'(pins_now()), 64'(IDLE));
        check("async_rst_ctr", 64'({vga_x, vga_y, frame_start}), 64'({10'd0, 10'd0, 1'b1}));
        run(3);
        release_reset();
        measure_hs_fall();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        run(3);
        @(negedge clk);
        check("reset_pins", 64'(pins_now()), 64'(IDLE));
        check("reset_ctr", 64'({vga_x, vga_y, frame_start}), 64'({10'd0, 10'd0, 1'b1}));
`ifdef VGA_FRAME_CNT_EN
        check("reset_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
        // Coordinate-echo pattern over two frames
        release_reset();
        measure_hs_fall();
        run(2 * F_TOT);
        // Constant white input: must only appear inside the active area
        @(negedge clk);
        ff_mode = 1'b1;
        run(F_TOT);
        // Reset inside the HS pulse, then inside the active area
        mid_reset(17, 1);
        run(F_TOT / 2);
        mid_reset(6, 1);
        @(negedge clk);
        ff_mode = 1'b0;
`ifdef VGA_FRAME_CNT_EN
        run(257 * F_TOT + 3);
`else
        run(3 * F_TOT);
`endif
        @(negedge clk);
        #2;
        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Raster timing generator and output stage for the VGA path.
- Drives pixel coordinates (oVGA_X, oVGA_Y) to the downstream-registered pattern generator, which returns RGB one clock later.
- Re-registers that RGB, blanks it outside the active area, and emits HS/VS/BLANK_N aligned to the returned pixels.
- Sits between the pattern generator and the DAC/connector pins.

Parameters:
H_ACT, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACT, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, HS active level (0 = active-low)
VS_POL, 0, VS active level (0 = active-low)

Ports:
iVGA_CLK  in  1  pixel clock
iRST_n  in  1  asynchronous active-low reset
iRed  in  8  red returned by the pattern generator
iGreen  in  8  green returned by the pattern generator
iBlue  in  8  blue returned by the pattern generator
oVGA_X  out  10  requested pixel column
oVGA_Y  out  10  requested pixel row
oVGA_R  out  8  red to DAC
oVGA_G  out  8  green to DAC
oVGA_B  out  8  blue to DAC
oVGA_HS  out  1  horizontal sync
oVGA_VS  out  1  vertical sync
oVGA_BLANK_N  out  1  high while the displayed pixel is active
oFrame_Start  out  1  1-clock pulse at counter position (0,0)

Behaviour:
- Reset: iRST_n is asynchronous, active-low; all logic is clocked on iVGA_CLK.
- Totals: H_TOT = H_ACT+H_FP+H_SYNC+H_BP (800 at defaults); V_TOT = V_ACT+V_FP+V_SYNC+V_BP (525 at defaults).
- Counters: h_cnt and v_cnt are 11-bit and reset to 0.
  - h_cnt increments every clock and wraps H_TOT-1 -> 0.
  - v_cnt increments only on the h_cnt wrap, and wraps V_TOT-1 -> 0 on the same edge as the h_cnt wrap.
- Raster order within each line and frame: active, front porch, sync, back porch.
- Stage 0 (decoded directly from the counter registers):
  - act = (h_cnt < H_ACT) && (v_cnt < V_ACT).
  - hs_a = h_cnt in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC), i.e. [656,752) at defaults.
  - vs_a = v_cnt in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC), i.e. [490,492) at defaults.
  - oVGA_X = h_cnt[9:0] when h_cnt < H_ACT, else 0. oVGA_Y = v_cnt[9:0] when v_cnt < V_ACT, else 0.
  - oFrame_Start = 1 while h_cnt==0 && v_cnt==0.
- Pipeline:
  - The pattern generator registers RGB for coordinate n at edge n+1.
  - This block captures iRed/iGreen/iBlue at edge n+2.
  - act, hs_a and vs_a pass through a 2-stage shift register so that oVGA_HS/VS/BLANK_N for position n are valid in the same cycle as its RGB.
  - Fixed total latency: counter position to pins = 2 clocks.
- Output stage:
  - oVGA_R/G/B = delayed act ? captured input : 0.
  - oVGA_BLANK_N = delayed act.
  - oVGA_HS = delayed hs_a ? HS_POL : ~HS_POL. oVGA_VS uses VS_POL the same way.
- Reset values:
  - h_cnt, v_cnt, oVGA_X, oVGA_Y = 0.
  - oVGA_R/G/B = 0; oVGA_BLANK_N = 0.
  - oVGA_HS = ~HS_POL; oVGA_VS = ~VS_POL (idle level, 1 at defaults).
  - Pipeline stages hold inactive values.
  - oFrame_Start = 1 while held in reset, since counters sit at (0,0).
- Reset mid-frame: everything returns to reset values immediately, without waiting for a clock. Timing restarts at (0,0) on the first edge after release. No partial sync pulse may be stretched: outputs go idle immediately.
- Wrap corner: at (H_TOT-1, V_TOT-1) both counters wrap to 0 on the same edge; v_cnt must never reach V_TOT.
- Sync at line granularity: vs_a toggles at h_cnt==0 of the line, so VS edges coincide with line starts (2-clock delayed at the pins).

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - Adds output oFrame_Cnt [7:0], reset 0.
  - Increments on the edge where the counters wrap to (0,0); wraps 255 -> 0.
  - Aligned to the counter domain, i.e. not delayed by the pipeline.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Release reset, run 2 lines -> HS low for exactly 96 clocks per line, starting 656+2 clocks after the line's h_cnt==0. BLANK_N high for exactly 640 clocks per line. Line period 800.
2. Run 1 full frame (420000 clocks) -> VS low for exactly 1600 clocks (2 lines) starting at line 490. oFrame_Start pulses exactly once per 420000 clocks.
3. Bench model returns iRed = registered oVGA_X[7:0] -> oVGA_R equals the column index: sequence 0,1,2,... starting when BLANK_N rises; 0 whenever BLANK_N = 0.
4. Drive iRed = iGreen = iBlue = 8'hFF constant -> oVGA_R/G/B = 0 during porches and sync, FF only while BLANK_N = 1. oVGA_X = 0 and oVGA_Y = 0 outside the active region.
5. Assert iRST_n low mid-line at h_cnt = 700 (inside HS) -> HS returns to 1, RGB and BLANK_N return to 0 immediately. After release, first HS falls 658 clocks later.
6. With VGA_FRAME_CNT_EN, run 257 frames -> oFrame_Cnt goes 0..255, then 0, then 1. With the macro undefined, the build has no oFrame_Cnt port.
